// File: rtl/bch_syndrome_serial_if.sv
// bch_syndrome_serial_if
//   Handshake bundle for the serial BCH syndrome generator.
//   Input side : in_valid / in_bit from the deserialiser, in_ready back.
//   Output side: out_valid / syndromes / err_detected to the error-locator
//                stage, out_ready back.
//   slave  modport: the syndrome generator.
//   master modport: the block feeding bits and consuming syndromes.
interface bch_syndrome_serial_if #(
  parameter int M = 4,
  parameter int T = 2
);
  logic               in_valid;
  logic               in_bit;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic [2*T*M-1:0]   syndromes;
  logic               err_detected;

  modport slave (
    input  in_valid,
    input  in_bit,
    input  out_ready,
    output in_ready,
    output out_valid,
    output syndromes,
    output err_detected
  );

  modport master (
    output in_valid,
    output in_bit,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  syndromes,
    input  err_detected
  );
endinterface

// File: rtl/bch_syndrome_serial.sv
// bch_syndrome_serial
//   Serial syndrome generator for a binary BCH(N,K) code over GF(2^M).
//   Takes one received coefficient per accepted handshake, r_{N-1} first,
//   and evaluates S_j = r(alpha^j), j = 1..2T, by Horner's rule.
//
//   Ports
//     clk    : rising-edge clock
//     rst    : synchronous, active-high reset
//     bus    : bch_syndrome_serial_if.slave
//              in_valid/in_bit/in_ready      - serial coefficient input
//              out_valid/out_ready           - syndrome handoff
//              syndromes[(j-1)*M +: M] = S_j
//              err_detected                  - any S_j nonzero
//     abort  : present only when BCH_SYND_ABORT_EN is defined; drops the
//              frame being accumulated
//
//   Build option: define BCH_SYND_ABORT_EN to add the abort port.
//
//   state  | meaning
//   -------+-------------------------------------------------------
//   ACCUM  | accepting bits, in_ready=1, syndromes accumulating
//   DONE   | frame complete, out_valid=1, outputs held until taken
module bch_syndrome_serial #(
  parameter int         M         = 4,
  parameter int         N         = 15,
  parameter int         T         = 2,
  parameter logic [M:0] PRIM_POLY = 5'b10011
) (
  input  logic clk,
  input  logic rst,
`ifdef BCH_SYND_ABORT_EN
  input  logic abort,
`endif
  bch_syndrome_serial_if.slave bus
);

  localparam int NS = 2 * T;
  localparam int CW = $clog2(N + 1);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_DONE  = 1'b1;

  logic [0:0]             state;
  logic [CW-1:0]          count;
  logic [NS-1:0][M-1:0]   synd_q;
  logic [NS-1:0][M-1:0]   synd_next;
  logic                   err_q;
  logic                   accept;
  logic                   last_bit;

  // Multiply by alpha: shift up one degree, fold x^M back via PRIM_POLY.
  function automatic logic [M-1:0] mul_alpha(input logic [M-1:0] x);
    mul_alpha = {x[M-2:0], 1'b0} ^ (x[M-1] ? PRIM_POLY[M-1:0] : {M{1'b0}});
  endfunction

  // Horner step per syndrome: S_j * alpha^j + r_i. alpha^j is built as
  // j chained alpha multiplies, which collapses to an XOR network.
  for (genvar j = 0; j < NS; j++) begin : g_synd
    logic [M-1:0] prod;

    always_comb begin
      prod = synd_q[j];
      for (int k = 0; k <= j; k++) begin
        prod = mul_alpha(prod);
      end
    end

    assign synd_next[j] = {prod[M-1:1], prod[0] ^ bus.in_bit};
  end

  // in_ready is gated by rst so it reads low during the reset cycle itself.
  assign bus.in_ready     = (state == ST_ACCUM) && !rst;
  assign bus.out_valid    = (state == ST_DONE);
  assign bus.syndromes    = synd_q;
  assign bus.err_detected = err_q;

  assign accept   = bus.in_valid && bus.in_ready;
  assign last_bit = (count == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_ACCUM;
      count  <= '0;
      synd_q <= '0;
      err_q  <= 1'b0;
    end else if (state == ST_ACCUM) begin
`ifdef BCH_SYND_ABORT_EN
      if (abort) begin
        count  <= '0;
        synd_q <= '0;
        err_q  <= 1'b0;
      end else
`endif
      if (accept) begin
        synd_q <= synd_next;
        if (last_bit) begin
          state <= ST_DONE;
          count <= '0;
          err_q <= |synd_next;
        end else begin
          count <= count + CW'(1);
        end
      end
    end else begin
      // Outputs stay frozen until the consumer takes them; the handoff
      // cycle itself accepts no input since in_ready is low in DONE.
      if (bus.out_ready) begin
        state  <= ST_ACCUM;
        synd_q <= '0;
        err_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bch_syndrome_serial.sv
module tb_bch_syndrome_serial;

  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef BCH_SYND_ABORT_EN
  logic abort = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bch_syndrome_serial_if #(.M(4), .T(2)) bus ();

  bch_syndrome_serial #(
    .M(4), .N(15), .T(2), .PRIM_POLY(5'b10011)
  ) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef BCH_SYND_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  // Directed vectors: frame bits f[i] = r_i, expected {S4,S3,S2,S1}.
  // GF(16), x^4+x+1: a^1=2 a^2=4 a^3=8 a^4=3 a^11=E a^12=F a^13=D a^14=9
  localparam int NV = 5;
  localparam logic [14:0] VEC_F [NV] = '{15'h01D1, 15'h0001, 15'h0002, 15'h4000, 15'h0003};
  localparam logic [15:0] VEC_S [NV] = '{16'h0000, 16'h1111, 16'h3842, 16'hEFD9, 16'h2953};
  localparam logic        VEC_E [NV] = '{1'b0,     1'b1,     1'b1,     1'b1,     1'b1};

  // Drives one 15-bit frame r14 first, honouring in_ready; returns #1 after
  // the edge that accepted the last bit.
  task automatic send_frame(input logic [14:0] f, input bit gaps);
    bit accepted;
    for (int i = 14; i >= 0; i--) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) begin
          bus.in_valid = 1'b0;
          bus.in_bit   = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
      bus.in_valid = 1'b1;
      bus.in_bit   = f[i];
      accepted = 1'b0;
      for (int w = 0; w < 20 && !accepted; w++) begin
        @(negedge clk);
        accepted = bus.in_ready;
        @(posedge clk); #1;
      end
      if (!accepted) begin
        checks++; failures++;
        $display("FAIL send_frame_timeout bit=%0d in_ready=%b required=1", i, bus.in_ready);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic handoff();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.syndromes !== 16'h0000) begin failures++; $display("FAIL reset_syndromes got=%h exp=0000", bus.syndromes); end
    checks++; if (bus.err_detected !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err_detected); end
    rst = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_zero_frame();
    bus.out_ready = 1'b1;
    send_frame(15'h0000, 1'b0);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL zero_out_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.syndromes !== 16'h0000) begin failures++; $display("FAIL zero_syndromes got=%h exp=0000", bus.syndromes); end
    checks++; if (bus.err_detected !== 1'b0) begin failures++; $display("FAIL zero_err got=%b exp=0", bus.err_detected); end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL zero_handoff_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL zero_handoff_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_vectors();
    for (int v = 0; v < NV; v++) begin
      bus.out_ready = 1'b0;
      send_frame(VEC_F[v], v[0]);
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL vec%0d_out_valid got=%b exp=1", v, bus.out_valid); end
      checks++; if (bus.syndromes !== VEC_S[v]) begin failures++; $display("FAIL vec%0d_syndromes got=%h exp=%h", v, bus.syndromes, VEC_S[v]); end
      checks++; if (bus.err_detected !== VEC_E[v]) begin failures++; $display("FAIL vec%0d_err got=%b exp=%b", v, bus.err_detected, VEC_E[v]); end
      handoff();
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    send_frame(15'h0002, 1'b0);
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      bus.in_bit   = 1'b1;
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp%0d_out_valid got=%b exp=1", k, bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp%0d_in_ready got=%b exp=0", k, bus.in_ready); end
      checks++; if (bus.syndromes !== 16'h3842) begin failures++; $display("FAIL bp%0d_syndromes got=%h exp=3842", k, bus.syndromes); end
      checks++; if (bus.err_detected !== 1'b1) begin failures++; $display("FAIL bp%0d_err got=%b exp=1", k, bus.err_detected); end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    handoff();
    checks++; if (bus.syndromes !== 16'h0000) begin failures++; $display("FAIL bp_cleared got=%h exp=0000", bus.syndromes); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_resume_in_ready got=%b exp=1", bus.in_ready); end
    send_frame(15'h0001, 1'b0);
    checks++; if (bus.syndromes !== 16'h1111) begin failures++; $display("FAIL bp_next_syndromes got=%h exp=1111", bus.syndromes); end
    handoff();
  endtask

  task automatic test_rst_mid_frame();
    for (int k = 0; k < 7; k++) begin
      bus.in_valid = 1'b1;
      bus.in_bit   = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rst_mid_in_ready got=%b exp=0", bus.in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.syndromes !== 16'h0000) begin failures++; $display("FAIL rst_mid_cleared got=%h exp=0000", bus.syndromes); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_out_valid got=%b exp=0", bus.out_valid); end
    send_frame(15'h0002, 1'b1);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL rst_gap_out_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.syndromes !== 16'h3842) begin failures++; $display("FAIL rst_gap_syndromes got=%h exp=3842", bus.syndromes); end
    checks++; if (bus.err_detected !== 1'b1) begin failures++; $display("FAIL rst_gap_err got=%b exp=1", bus.err_detected); end
    handoff();
  endtask

`ifdef BCH_SYND_ABORT_EN
  task automatic test_abort();
    for (int k = 0; k < 7; k++) begin
      bus.in_valid = 1'b1;
      bus.in_bit   = 1'b1;
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    bus.in_valid = 1'b0;
    checks++; if (bus.syndromes !== 16'h0000) begin failures++; $display("FAIL abort_cleared got=%h exp=0000", bus.syndromes); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL abort_in_ready got=%b exp=1", bus.in_ready); end
    send_frame(15'h0002, 1'b1);
    checks++; if (bus.syndromes !== 16'h3842) begin failures++; $display("FAIL abort_syndromes got=%h exp=3842", bus.syndromes); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL abort_done_out_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.syndromes !== 16'h3842) begin failures++; $display("FAIL abort_done_syndromes got=%h exp=3842", bus.syndromes); end
    handoff();
  endtask
`endif

  task automatic test_back_to_back();
    int t0;
    int t1;
    bus.out_ready = 1'b1;
    send_frame(15'h0001, 1'b0);
    t0 = cyc;
    checks++; if (bus.syndromes !== 16'h1111) begin failures++; $display("FAIL b2b_a_syndromes got=%h exp=1111", bus.syndromes); end
    send_frame(15'h0002, 1'b0);
    t1 = cyc;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL b2b_b_out_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.syndromes !== 16'h3842) begin failures++; $display("FAIL b2b_b_syndromes got=%h exp=3842", bus.syndromes); end
    checks++; if ((t1 - t0) !== 16) begin failures++; $display("FAIL b2b_period got=%0d exp=16", t1 - t0); end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_frame();
    test_vectors();
    test_backpressure();
    test_rst_mid_frame();
`ifdef BCH_SYND_ABORT_EN
    test_abort();
`endif
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time_expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
